serial_ripple_subtractor: RTL and testbench
===========================================

Name: serial_ripple_subtractor

Overview:
- Bit-serial subtractor, the inverse of the team's parallel ripple-carry adder. Computes diff = a - b - bin one bit per clock through a single full-subtractor cell with a registered borrow.
- Trades area for latency.
- Sits behind a valid/ready operand interface and presents its result on a valid/ready result interface, so it can be dropped into the arithmetic datapath next to the adder.

Parameters:
- WIDTH, 4, operand/result width in bits; legal range >= 1.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands a, b, bin are valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  minuend, unsigned.
- b  input  WIDTH  subtrahend, unsigned.
- bin  input  1  borrow-in.
- out_valid  output  1  diff/bout hold a completed result.
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  (a - b - bin) mod 2^WIDTH.
- bout  output  1  final borrow; 1 iff a < b + bin (unsigned).

Behaviour:
- Reset (rst_n low, takes effect immediately, asynchronously):
  - state = IDLE.
  - in_ready = 1, out_valid = 0, diff = 0, bout = 0.
  - Shift registers, borrow register and bit counter = 0.
- States: IDLE, RUN, DONE. in_ready = (state == IDLE), decoded combinationally from the state register. out_valid = (state == DONE), registered.
- IDLE:
  - On a rising edge with in_valid && in_ready: capture a, b into right-shift registers and bin into the borrow register, clear the bit counter, go to RUN.
  - With in_valid low: stay in IDLE.
- RUN, each cycle:
  - d = a_sh[0] ^ b_sh[0] ^ brw.
  - brw_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & brw).
  - Shift d into the MSB of the result shift register; shift a_sh and b_sh right by one; increment the counter.
  - In the cycle where counter == WIDTH-1: load diff from the completed result shift register, load bout from brw_next, go to DONE.
  - in_valid is ignored in RUN and in DONE; operands presented there are not captured.
- Latency: operands accepted at edge N -> out_valid high after edge N+WIDTH, i.e. exactly WIDTH cycles in RUN.
- DONE:
  - diff, bout and out_valid are held stable until out_valid && out_ready at a rising edge; then go to IDLE.
  - in_ready returns high the cycle after the result handshake. There is no back-to-back accept in the same cycle as the result handshake.
  - out_ready high while not in DONE has no effect.
- diff and bout change only on the RUN->DONE transition or on reset. They retain the last result while in IDLE/RUN after the handshake; consumers qualify them with out_valid.
- WIDTH = 1: a single RUN cycle; result equals a full-subtractor output.
- Counter width: $clog2(WIDTH) bits, minimum 1. The counter must not wrap before the terminal compare.
- Reset asserted mid-RUN or mid-DONE: the operation is aborted with no result and no out_valid pulse. After rst_n rises the block is in IDLE and accepts new operands on the next edge.

Decomposition:
- Shared package/include holds the state encodings (IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10) and DEFAULT_WIDTH = 4. The bench reuses both.
- One combinational sub-module, full_subtractor (ports a, b, bin, d, bout), is the bit-serial cell. It is the borrow-chain dual of the existing full-adder cell and is reusable for a parallel ripple-borrow subtractor.

Test Plan:
1. WIDTH=4: a=9, b=3, bin=0, out_ready=1 -> out_valid exactly 4 cycles after accept; diff=6, bout=0; in_ready high 1 cycle after the result handshake.
2. a=3, b=9, bin=0 -> diff=10, bout=1; a=0, b=0, bin=1 -> diff=15, bout=1 (borrow ripples through every bit).
3. a=15, b=0, bin=1 -> diff=14, bout=0; a=7, b=7, bin=0 -> diff=0, bout=0.
4. Backpressure: a=12, b=5, bin=0, out_ready held low 5 cycles in DONE -> out_valid, diff=7, bout=0 stable throughout. in_ready=0; an in_valid pulse with a=1, b=1 is not captured. Raise out_ready -> IDLE next cycle.
5. Reset abort: accept a=10, b=4; pull rst_n low in the 2nd RUN cycle -> out_valid=0, diff=0, bout=0, in_ready=1 immediately. Release, then send a=5, b=2, bin=0 -> diff=3, bout=0 after 4 cycles.
6. 10 random {a, b, bin} vectors back-to-back with random out_ready stalls -> every diff/bout matches (a-b-bin) mod 16 and the unsigned borrow; no result lost or duplicated.

Source files
------------

// File: rtl/serial_ripple_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: state encodings,
// the default operand width and the bit-counter sizing helper.
package serial_ripple_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // The counter only has to reach WIDTH-1, but a zero-width vector is not legal.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_ripple_subtractor_fs.sv
// Combinational full-subtractor cell: d = a - b - bin, bout is the borrow out.
// Borrow-chain dual of the full-adder cell; chains directly into a ripple-borrow subtractor.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin computed LSB first, one bit per clock,
// through a single full_subtractor cell with a registered borrow.
module serial_ripple_subtractor
    import serial_ripple_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic [1:0]       dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // Operands are taken only in IDLE (in_ready); the result is held with
    // out_valid in DONE until out_ready, and valid never drops without a transfer.

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_next;
    logic             brw;
    logic [CW-1:0]    cnt;
    logic             d;
    logic             brw_next;
    logic             unused_lsb;

    full_subtractor u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (brw),
        .d    (d),
        .bout (brw_next)
    );

    // The new bit enters at the MSB, so after WIDTH shifts bit 0 sits at the LSB.
    generate
        if (WIDTH == 1) begin : g_w1
            assign r_next = d;
        end else begin : g_wn
            assign r_next = {d, r_sh[WIDTH-1:1]};
        end
    endgenerate

    assign unused_lsb = r_sh[0];
    assign in_ready   = (state == IDLE);
    assign dbg_state  = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            r_sh      <= '0;
            brw       <= 1'b0;
            cnt       <= '0;
            diff      <= '0;
            bout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        brw   <= bin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    r_sh <= r_next;
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    brw  <= brw_next;
                    if (cnt == LAST) begin
                        cnt       <= '0;
                        diff      <= r_next;
                        bout      <= brw_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Directed and random checks of serial_ripple_subtractor against an arithmetic
// reference model, with a scoreboard queue of expected {bout, diff} results.
module tb_serial_ripple_subtractor;
    import serial_ripple_subtractor_pkg::*;

    localparam int W = DEFAULT_WIDTH;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic [1:0]   dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [W:0] exp_q[$];

    serial_ripple_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation timeout");
    end

    // ---------------- reference model ----------------
    function automatic logic [W:0] model(input int ua, input int ub, input int ubin);
        int          r;
        logic [31:0] rv;
        logic        borrow;
        r      = ua - ub - ubin;
        rv     = r;
        borrow = (ua < ub + ubin);
        return {borrow, rv[W-1:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    // One full transaction: accept, latency check, optional stall in DONE
    // (with an ignored in_valid pulse), result handshake, in_ready return.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tbin, input int stall, input logic pulse);
        int         lat;
        int         waitc;
        logic [W:0] exp;
        waitc = 0;
        while (!in_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        check("in_ready_before_accept", in_ready, 1);
        exp_q.push_back(model(int'(ta), int'(tb), int'(tbin)));
        a         = ta;
        b         = tb;
        bin       = tbin;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        @(negedge clk);
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        bin      = 1'($urandom);
        check("state_run", dbg_state, RUN);
        lat = 0;
        while (!out_valid && lat < W + 10) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, W);
        exp = exp_q.pop_front();
        check("diff", diff, exp[W-1:0]);
        check("bout", bout, exp[W]);
        for (int i = 0; i < stall; i++) begin
            if (pulse && i == 0) begin
                a        = 1;
                b        = 1;
                in_valid = 1'b1;
            end
            @(negedge clk);
            in_valid = 1'b0;
            check("stall_valid", out_valid, 1);
            check("stall_diff", diff, exp[W-1:0]);
            check("stall_bout", bout, exp[W]);
            check("stall_in_ready", in_ready, 0);
        end
        check("in_ready_in_done", in_ready, 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'($urandom);
        check("post_hs_valid", out_valid, 0);
        check("post_hs_in_ready", in_ready, 1);
        check("post_hs_diff_held", diff, exp[W-1:0]);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_diff", diff, 0);
        check("rst_bout", bout, 0);
        check("rst_state", dbg_state, IDLE);
        rst_n = 1'b1;
        @(negedge clk);

        // basic, borrow cases, full ripple, no-borrow with bin, equal operands
        do_op(4'd9,  4'd3, 1'b0, 0, 1'b0);
        do_op(4'd3,  4'd9, 1'b0, 0, 1'b0);
        do_op(4'd0,  4'd0, 1'b1, 0, 1'b0);
        do_op(4'd15, 4'd0, 1'b1, 0, 1'b0);
        do_op(4'd7,  4'd7, 1'b0, 0, 1'b0);

        // backpressure with an ignored in_valid pulse in DONE
        do_op(4'd12, 4'd5, 1'b0, 5, 1'b1);
        check("no_capture_in_done", exp_q.size(), 0);

        // reset abort in the second RUN cycle
        @(negedge clk);
        a        = 4'd10;
        b        = 4'd4;
        bin      = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("abort_state_before", dbg_state, RUN);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_diff", diff, 0);
        check("abort_bout", bout, 0);
        check("abort_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < W + 2; i++) begin
            @(negedge clk);
            check("abort_no_pulse", out_valid, 0);
        end
        do_op(4'd5, 4'd2, 1'b0, 0, 1'b0);

        // random back-to-back operations with random stalls
        for (int i = 0; i < 10; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom),
                  int'($urandom_range(0, 3)), 1'($urandom));
        end
        check("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
